dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter address_size, default 32, width of data/address buses.
REQ-002 Parameter ram_words, default 1024, number of 32-bit words in the external data RAM.
REQ-003 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port RESET  input  1  reset, asynchronous, active-high.
REQ-005 Port daddr  input  address_size  byte address from the core MEM stage.
REQ-006 Port ddata_w  input  address_size  store data from the core.
REQ-007 Port MemRead / MemWrite  input  1 each  access strobes from the core, valid for one cycle per access.
REQ-008 Port ddata_r  output  address_size  load data to the core, combinational in the same cycle.
REQ-009 Port ram_addr  output  log2(ram_words)  word index to the RAM, equal to daddr[11:2].
REQ-010 Port ram_wdata  output  address_size  equal to ddata_w.
REQ-011 Port ram_we  output  1  RAM write enable.
REQ-012 Port ram_rdata  input  address_size  asynchronous-read RAM data.
REQ-013 Port gpio_in  input  32  asynchronous external inputs.
REQ-014 Port gpio_out  output  32  registered GPIO output.
REQ-015 Port timer_irq  output  1  level, equals the timer match flag.
REQ-016 Port bus_err  output  1  sticky access-error flag.

Function
REQ-017 Address map: 0x0000-0x0FFF RAM; 0x1000 GPIO_OUT (RW); 0x1004 GPIO_IN (RO); 0x1008 TIMER_CNT (RW); 0x100C TIMER_CMP (RW); 0x1010 TIMER_CTRL (RW: bit0 EN, bit1 RELOAD, bit2 MATCH, write-1-to-clear); all bits of daddr above bit 12 are decoded and must be zero.
REQ-018 ram_we = MemWrite & ~MemRead & RAM region & daddr[1:0]==0.
REQ-019 Read: ddata_r = ram_rdata for RAM, the register value for peripherals, TIMER_CTRL reads {29'b0,MATCH,RELOAD,EN}; 0 when MemRead low, for unmapped addresses, or on error.
REQ-020 GPIO_IN reads the value after a 2-flop synchronizer, i.e. 2-cycle latency from gpio_in.
REQ-021 Peripheral writes take effect at the next rising edge; a following load sees the new value.
REQ-022 TIMER_CNT increments by 1 each cycle when EN=1, wrapping 0xFFFFFFFF -> 0.
REQ-023 Match condition: EN=1 and TIMER_CNT==TIMER_CMP; at the next edge MATCH is set, and TIMER_CNT loads 0 if RELOAD=1, otherwise increments.
REQ-024 A CPU write to TIMER_CNT in the same cycle as an increment or reload: the written value wins.
REQ-025 A MATCH set and a W1C clear in the same cycle: set wins.
REQ-026 A TIMER_CTRL write updates EN/RELOAD from bits 0/1 and clears MATCH only if bit2=1.
REQ-027 Error conditions, each setting bus_err at the next edge: MemRead&MemWrite both high; misaligned address (daddr[1:0]!=0) with any strobe; strobe to an unmapped address; write to GPIO_IN.
REQ-028 An access in error performs no state change and no RAM write.
REQ-029 bus_err clears only on RESET.

Reset
REQ-030 On RESET assertion, immediately and independent of CLK: gpio_out=0, TIMER_CNT=0, TIMER_CMP=0xFFFFFFFF, EN=RELOAD=MATCH=0, bus_err=0, synchronizer flops=0; timer_irq=0.
REQ-031 Reset asserted mid-operation aborts any pending update; ram_we is 0 while RESET is high.
REQ-032 First register update occurs at the first rising edge after RESET deasserts.

Verification
REQ-033 Write 0xA5A5_0F0F to 0x1000, then read 0x1000 -> gpio_out and ddata_r = 0xA5A50F0F from the next cycle on.
REQ-034 CMP=5, CTRL=0x3 -> CNT sequence 0,1,2,3,4,5,0,1; timer_irq=1 from the cycle after CNT=5; write 0x4 to CTRL -> irq=0 unless a new match occurs in the same cycle.
REQ-035 CNT=0xFFFFFFFF, CMP=3, EN=1, RELOAD=0 -> CNT wraps to 0, reaches 3, MATCH set, counting continues to 4.
REQ-036 Store to 0x0008 with data 0x12345678 -> ram_we=1, ram_addr=2, ram_wdata=0x12345678 in that cycle; store to 0x0006 -> ram_we=0, bus_err=1 at the next edge.
REQ-037 Load from 0x2000 -> ddata_r=0, bus_err=1; MemRead&MemWrite to 0x1000 -> gpio_out unchanged, bus_err=1.
REQ-038 gpio_in toggles to 0x1 -> a read of 0x1004 returns 1 exactly 2 edges later; RESET pulse mid-count -> every output returns to its REQ-030 value without a clock edge.

Source files
------------

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - data-memory bridge: RAM pass-through, GPIO and a compare/reload timer.
module dmem_bridge #(
    parameter int address_size = 32,
    parameter int ram_words    = 1024
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [address_size-1:0]      daddr,
    input  logic [address_size-1:0]      ddata_w,
    input  logic                         MemRead,
    input  logic                         MemWrite,
    output logic [address_size-1:0]      ddata_r,
    output logic [$clog2(ram_words)-1:0] ram_addr,
    output logic [address_size-1:0]      ram_wdata,
    output logic                         ram_we,
    input  logic [address_size-1:0]      ram_rdata,
    input  logic [31:0]                  gpio_in,
    output logic [31:0]                  gpio_out,
    output logic                         timer_irq,
    output logic                         bus_err
);
    localparam int AW = $clog2(ram_words);

    logic [31:0] gpio_out_q, gpio_out_d;
    logic [31:0] sync1_q, sync2_q;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d, reload_q, reload_d, match_q, match_d;
    logic        err_q;

    logic upper_zero, in_ram, periph, misaligned, strobe, mapped, err, wr_ok, rd_ok, hit;
    logic sel_gout, sel_gin, sel_cnt, sel_cmp, sel_ctrl;

    assign upper_zero = (daddr[address_size-1:13] == '0);
    assign in_ram     = upper_zero && !daddr[12];
    assign periph     = upper_zero && daddr[12];
    assign sel_gout   = periph && (daddr[11:0] == 12'h000);
    assign sel_gin    = periph && (daddr[11:0] == 12'h004);
    assign sel_cnt    = periph && (daddr[11:0] == 12'h008);
    assign sel_cmp    = periph && (daddr[11:0] == 12'h00C);
    assign sel_ctrl   = periph && (daddr[11:0] == 12'h010);
    assign mapped     = in_ram || sel_gout || sel_gin || sel_cnt || sel_cmp || sel_ctrl;
    assign misaligned = (daddr[1:0] != 2'b00);
    assign strobe     = MemRead || MemWrite;

    // Any error condition squashes both the register update and the read data.
    assign err   = strobe && ((MemRead && MemWrite) || misaligned || !mapped || (MemWrite && sel_gin));
    assign wr_ok = MemWrite && !MemRead && !err;
    assign rd_ok = MemRead && !MemWrite && !err;
    assign hit   = en_q && (cnt_q == cmp_q);

    assign ram_addr  = daddr[AW+1:2];
    assign ram_wdata = ddata_w;
    assign ram_we    = wr_ok && in_ram && !RESET;
    assign gpio_out  = gpio_out_q;
    assign timer_irq = match_q;
    assign bus_err   = err_q;

    always_comb begin
        ddata_r = '0;
        if (rd_ok) begin
            if (in_ram)        ddata_r = ram_rdata;
            else if (sel_gout) ddata_r = gpio_out_q;
            else if (sel_gin)  ddata_r = sync2_q;
            else if (sel_cnt)  ddata_r = cnt_q;
            else if (sel_cmp)  ddata_r = cmp_q;
            else if (sel_ctrl) ddata_r = {29'b0, match_q, reload_q, en_q};
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        cmp_d      = cmp_q;
        en_d       = en_q;
        reload_d   = reload_q;
        match_d    = match_q;
        cnt_d      = cnt_q;
        if (en_q) cnt_d = (hit && reload_q) ? 32'd0 : cnt_q + 32'd1;
        if (wr_ok) begin
            if (sel_gout) gpio_out_d = ddata_w;
            if (sel_cnt)  cnt_d      = ddata_w;
            if (sel_cmp)  cmp_d      = ddata_w;
            if (sel_ctrl) begin
                en_d     = ddata_w[0];
                reload_d = ddata_w[1];
                if (ddata_w[2]) match_d = 1'b0;
            end
        end
        // A match in the same cycle as a write-1-to-clear keeps the flag set.
        if (hit) match_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            cmp_q      <= 32'hFFFF_FFFF;
            en_q       <= 1'b0;
            reload_q   <= 1'b0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
            en_q       <= en_d;
            reload_q   <= reload_d;
            match_q    <= match_d;
            err_q      <= err_q || err;
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge.
module tb_dmem_bridge;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] daddr, ddata_w, ram_rdata, gpio_in;
    logic        MemRead, MemWrite;
    logic [31:0] ddata_r, ram_wdata, gpio_out;
    logic [9:0]  ram_addr;
    logic        ram_we, timer_irq, bus_err;

    int total = 0;
    int bad   = 0;

    dmem_bridge #(.address_size(32), .ram_words(1024)) dut (
        .CLK(CLK), .RESET(RESET), .daddr(daddr), .ddata_w(ddata_w),
        .MemRead(MemRead), .MemWrite(MemWrite), .ddata_r(ddata_r),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .timer_irq(timer_irq), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge with strobes low.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        daddr = a; ddata_w = d; MemWrite = 1'b1; MemRead = 1'b0;
        @(negedge CLK);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        daddr = a; MemRead = 1'b1; MemWrite = 1'b0;
        #1 d = ddata_r;
        @(negedge CLK);
        MemRead = 1'b0;
    endtask

    task automatic pulse_reset;
        RESET = 1'b1;
        #2 RESET = 1'b0;
    endtask

    logic [31:0] v;
    logic [31:0] seq34 [8];
    logic [31:0] seq35 [6];

    initial begin
        seq34 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        seq35 = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
        RESET = 1'b1; daddr = 32'h8; ddata_w = 32'h0; ram_rdata = 32'h0; gpio_in = 32'h0;
        MemRead = 1'b0; MemWrite = 1'b1;
        #1;
        chk("rst_gpio_out", gpio_out, 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        MemWrite = 1'b0; MemRead = 1'b1; daddr = 32'h100C;
        #1 chk("rst_cmp", ddata_r, 32'hFFFF_FFFF);
        MemRead = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // GPIO_OUT write then read back
        wr(32'h1000, 32'hA5A5_0F0F);
        chk("gpio_out", gpio_out, 32'hA5A5_0F0F);
        rd(32'h1000, v);
        chk("gpio_rd", v, 32'hA5A5_0F0F);
        chk("no_err", 32'(bus_err), 32'h0);

        // GPIO_IN two-flop latency
        gpio_in = 32'h1; daddr = 32'h1004; MemRead = 1'b1;
        #1 chk("gin_0edge", ddata_r, 32'h0);
        @(negedge CLK);
        #1 chk("gin_1edge", ddata_r, 32'h0);
        @(negedge CLK);
        #1 chk("gin_2edge", ddata_r, 32'h1);
        @(negedge CLK);
        MemRead = 1'b0;

        // Timer reload sequence and irq
        wr(32'h100C, 32'd5);
        wr(32'h1010, 32'h3);
        daddr = 32'h1008; MemRead = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("cnt34", ddata_r, seq34[i]);
            chk("irq34", 32'(timer_irq), (i >= 6) ? 32'h1 : 32'h0);
            @(negedge CLK);
        end
        MemRead = 1'b0;
        wr(32'h1010, 32'h4);
        chk("irq_clr", 32'(timer_irq), 32'h0);
        rd(32'h1010, v);
        chk("ctrl_rd", v, 32'h0);

        // Match set beats W1C in the same cycle
        wr(32'h1008, 32'd5);
        wr(32'h1010, 32'h3);
        wr(32'h1010, 32'h7);
        chk("set_wins", 32'(timer_irq), 32'h1);
        rd(32'h1010, v);
        chk("ctrl_rd2", v, 32'h7);

        // CPU write to CNT beats the increment
        wr(32'h1008, 32'd100);
        rd(32'h1008, v);
        chk("cnt_wr_wins", v, 32'd100);
        wr(32'h1010, 32'h4);
        chk("irq_clr2", 32'(timer_irq), 32'h0);

        // Wrap with RELOAD=0
        wr(32'h100C, 32'd3);
        wr(32'h1008, 32'hFFFF_FFFF);
        wr(32'h1010, 32'h1);
        daddr = 32'h1008; MemRead = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cnt35", ddata_r, seq35[i]);
            chk("irq35", 32'(timer_irq), (i == 5) ? 32'h1 : 32'h0);
            @(negedge CLK);
        end
        MemRead = 1'b0;

        // RAM store, misaligned store, RAM load
        daddr = 32'h8; ddata_w = 32'h1234_5678; MemWrite = 1'b1;
        #1;
        chk("ram_we", 32'(ram_we), 32'h1);
        chk("ram_addr", 32'(ram_addr), 32'h2);
        chk("ram_wdata", ram_wdata, 32'h1234_5678);
        @(negedge CLK);
        daddr = 32'h6;
        #1;
        chk("misal_we", 32'(ram_we), 32'h0);
        chk("misal_err_pre", 32'(bus_err), 32'h0);
        @(negedge CLK);
        MemWrite = 1'b0;
        #1 chk("misal_err", 32'(bus_err), 32'h1);
        daddr = 32'h10; ram_rdata = 32'hDEAD_BEEF; MemRead = 1'b1;
        #1 chk("ram_rd", ddata_r, 32'hDEAD_BEEF);
        MemRead = 1'b0;
        #1 chk("rd_idle", ddata_r, 32'h0);
        @(negedge CLK);

        // Asynchronous reset mid-count
        #3 RESET = 1'b1;
        #1;
        chk("arst_gpio", gpio_out, 32'h0);
        chk("arst_irq", 32'(timer_irq), 32'h0);
        chk("arst_err", 32'(bus_err), 32'h0);
        daddr = 32'h1004; MemRead = 1'b1;
        #1 chk("arst_sync", ddata_r, 32'h0);
        daddr = 32'h1008;
        #1 chk("arst_cnt", ddata_r, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        #1 chk("post_rst_cnt", ddata_r, 32'h0);
        MemRead = 1'b0;
        @(negedge CLK);

        // Unmapped load
        daddr = 32'h2000; MemRead = 1'b1;
        #1 chk("unmap_rd", ddata_r, 32'h0);
        @(negedge CLK);
        MemRead = 1'b0;
        #1 chk("unmap_err", 32'(bus_err), 32'h1);
        @(negedge CLK);

        // Both strobes together
        pulse_reset();
        @(negedge CLK);
        wr(32'h1000, 32'h55);
        daddr = 32'h1000; ddata_w = 32'h0; MemRead = 1'b1; MemWrite = 1'b1;
        #1 chk("both_rd", ddata_r, 32'h0);
        @(negedge CLK);
        MemRead = 1'b0; MemWrite = 1'b0;
        chk("both_gpio", gpio_out, 32'h55);
        chk("both_err", 32'(bus_err), 32'h1);

        // Write to read-only GPIO_IN, high address bit, unmapped peripheral slot
        pulse_reset();
        @(negedge CLK);
        wr(32'h1004, 32'h1);
        chk("gin_wr_err", 32'(bus_err), 32'h1);
        pulse_reset();
        @(negedge CLK);
        wr(32'h8000_1000, 32'h7);
        chk("hi_gpio", gpio_out, 32'h0);
        chk("hi_err", 32'(bus_err), 32'h1);
        pulse_reset();
        @(negedge CLK);
        wr(32'h1014, 32'h7);
        chk("slot_err", 32'(bus_err), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
